// File: rtl/spi_flash_pkg.sv
// Shared constants, FSM state type and opcode decoder for the SPI NOR-flash emulator.
package spi_flash_pkg;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR1 = 8'h05;
  localparam logic [7:0] OP_RDSR2 = 8'h35;
  localparam logic [7:0] OP_WRSR  = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_QREAD = 8'h6B;

  localparam int unsigned SR_BUSY = 0;
  localparam int unsigned SR_WEL  = 1;
  localparam int unsigned SR_QE   = 1;

  localparam int unsigned DUMMY_CLKS = 8;
  localparam int unsigned ADDR_BITS  = 24;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StDataOut,
    StSrOut,
    StSrIn,
    StIgnore
  } state_e;

  // While BUSY only the status reads are honoured; QREAD needs QE set.
  function automatic state_e decode_op(input logic [7:0] op, input logic busy, input logic qe);
    if (busy && op != OP_RDSR1 && op != OP_RDSR2) return StIgnore;
    case (op)
      OP_RDSR1, OP_RDSR2: return StSrOut;
      OP_WRSR:            return StSrIn;
      OP_READ:            return StAddr;
      OP_QREAD:           return qe ? StAddr : StIgnore;
      default:            return StIgnore;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_model_if.sv
// SPI control lines, preload port and status outputs of the flash emulator.
interface spi_flash_model_if #(
  parameter int unsigned MEM_DEPTH = 256
) ();
  logic                         SCLK;
  logic                         CS_N;
  logic                         pre_we;
  logic [$clog2(MEM_DEPTH)-1:0] pre_addr;
  logic [7:0]                   pre_wdata;
  logic [7:0]                   sr1;
  logic [7:0]                   sr2;

  modport master (
    output SCLK, CS_N, pre_we, pre_addr, pre_wdata,
    input  sr1, sr2
  );

  modport slave (
    input  SCLK, CS_N, pre_we, pre_addr, pre_wdata,
    output sr1, sr2
  );
endinterface

// File: rtl/spi_flash_model_edge_sync.sv
// Two-flop synchronisers for the SPI pins plus single-cycle edge pulses on SCLK and CS_N.
module spi_edge_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic [3:0] io,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       cs_rise,
  output logic       cs_fall,
  output logic       cs_n_sync,
  output logic [3:0] io_sync
);

  logic [1:0] sclk_ff;
  logic [1:0] cs_ff;
  logic [3:0] io_ff1;
  logic [3:0] io_ff2;
  logic       sclk_prev;
  logic       cs_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_ff   <= 2'b00;
      cs_ff     <= 2'b11;
      io_ff1    <= 4'h0;
      io_ff2    <= 4'h0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_ff   <= {sclk_ff[0], sclk};
      cs_ff     <= {cs_ff[0], cs_n};
      io_ff1    <= io;
      io_ff2    <= io_ff1;
      sclk_prev <= sclk_ff[1];
      cs_prev   <= cs_ff[1];
    end
  end

  assign sclk_rise = sclk_ff[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_ff[1] & sclk_prev;
  assign cs_rise   = cs_ff[1] & ~cs_prev;
  assign cs_fall   = ~cs_ff[1] & cs_prev;
  assign cs_n_sync = cs_ff[1];
  assign io_sync   = io_ff2;

endmodule

// File: rtl/spi_flash_model.sv
// SPI NOR-flash slave emulator: status registers, timed BUSY, byte array, single and quad reads.
module spi_flash_model
  import spi_flash_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned BUSY_CYCLES = 64,
  parameter logic [7:0]  SR2_RESET   = 8'h00
) (
  input logic               ACLK,
  input logic               ARESET,
  inout wire                IO0,
  inout wire                IO1,
  inout wire                IO2,
  inout wire                IO3,
  spi_flash_model_if.slave  bus
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned BW = $clog2(BUSY_CYCLES + 1);

  logic       sclk_rise, sclk_fall, cs_rise, cs_fall, cs_n_s;
  logic [3:0] io_s;

  spi_edge_sync u_sync (
    .clk       (ACLK),
    .rst       (ARESET),
    .sclk      (bus.SCLK),
    .cs_n      (bus.CS_N),
    .io        ({IO3, IO2, IO1, IO0}),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall),
    .cs_n_sync (cs_n_s),
    .io_sync   (io_s)
  );

  // Only IO0 carries master data in the supported command set.
  logic unused_io;
  assign unused_io = ^io_s[3:1];

  logic [7:0] mem [MEM_DEPTH];

  state_e         state_q;
  logic [4:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic [AW-1:0]  addr_q;
  logic           quad_q;
  logic           sel_sr2_q;
  logic [15:0]    sr_in_q;
  logic [4:0]     sr_in_cnt_q;
  logic           wren_q;
  logic           wrdi_q;
  logic [3:0]     oe_q;
  logic [3:0]     out_q;
  logic [7:0]     sr1_q;
  logic [7:0]     sr2_q;
  logic [BW-1:0]  busy_cnt_q;

  logic [7:0] cmd_next;
  logic [7:0] sr_live;
  logic [7:0] mem_byte;

  assign cmd_next = {shift_q[6:0], io_s[0]};
  assign sr_live  = sel_sr2_q ? sr2_q : sr1_q;
  assign mem_byte = mem[addr_q];

  // Preload port has priority only in the sense that the fetch in the same cycle sees the old byte.
  always_ff @(posedge ACLK) begin
    if (bus.pre_we) mem[bus.pre_addr] <= bus.pre_wdata;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      quad_q      <= 1'b0;
      sel_sr2_q   <= 1'b0;
      sr_in_q     <= '0;
      sr_in_cnt_q <= '0;
      wren_q      <= 1'b0;
      wrdi_q      <= 1'b0;
      oe_q        <= '0;
      out_q       <= '0;
      sr1_q       <= '0;
      sr2_q       <= SR2_RESET;
      busy_cnt_q  <= '0;
    end else begin
      if (busy_cnt_q != '0) begin
        busy_cnt_q <= busy_cnt_q - BW'(1);
        if (busy_cnt_q == BW'(1)) begin
          sr1_q[SR_BUSY] <= 1'b0;
          sr1_q[SR_WEL]  <= 1'b0;
        end
      end

      if (cs_n_s) begin
        state_q <= StIdle;
        oe_q    <= '0;
        wren_q  <= 1'b0;
        wrdi_q  <= 1'b0;
        if (cs_rise) begin
          if (wren_q) sr1_q[SR_WEL] <= 1'b1;
          if (wrdi_q) sr1_q[SR_WEL] <= 1'b0;
          if (state_q == StSrIn && sr_in_cnt_q == 5'd16 && sr1_q[SR_WEL]) begin
            // BUSY and WEL both read as set until the countdown expires.
            sr1_q      <= {sr_in_q[15:10], 2'b11};
            sr2_q      <= sr_in_q[7:0];
            busy_cnt_q <= BW'(BUSY_CYCLES);
          end
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cs_fall) begin
              state_q   <= StCmd;
              bit_cnt_q <= '0;
            end
          end
          StCmd: begin
            if (sclk_rise) begin
              shift_q <= cmd_next;
              if (bit_cnt_q == 5'd7) begin
                state_q     <= decode_op(cmd_next, sr1_q[SR_BUSY], sr2_q[SR_QE]);
                bit_cnt_q   <= '0;
                wren_q      <= (cmd_next == OP_WREN) && !sr1_q[SR_BUSY];
                wrdi_q      <= (cmd_next == OP_WRDI) && !sr1_q[SR_BUSY];
                quad_q      <= (cmd_next == OP_QREAD);
                sel_sr2_q   <= (cmd_next == OP_RDSR2);
                sr_in_cnt_q <= '0;
                addr_q      <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          StAddr: begin
            if (sclk_rise) begin
              addr_q <= AW'({addr_q, io_s[0]});
              if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
                state_q   <= quad_q ? StDummy : StDataOut;
                bit_cnt_q <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          StDummy: begin
            if (sclk_rise) begin
              if (bit_cnt_q == 5'(DUMMY_CLKS - 1)) begin
                state_q   <= StDataOut;
                bit_cnt_q <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          StDataOut: begin
            if (sclk_fall) begin
              if (quad_q) begin
                oe_q <= 4'hF;
                if (bit_cnt_q == '0) begin
                  out_q     <= mem_byte[7:4];
                  shift_q   <= mem_byte;
                  addr_q    <= addr_q + AW'(1);
                  bit_cnt_q <= 5'd1;
                end else begin
                  out_q     <= shift_q[3:0];
                  bit_cnt_q <= '0;
                end
              end else begin
                oe_q <= 4'b0010;
                if (bit_cnt_q == '0) begin
                  out_q     <= {2'b00, mem_byte[7], 1'b0};
                  shift_q   <= {mem_byte[6:0], 1'b0};
                  addr_q    <= addr_q + AW'(1);
                  bit_cnt_q <= 5'd7;
                end else begin
                  out_q     <= {2'b00, shift_q[7], 1'b0};
                  shift_q   <= {shift_q[6:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q - 5'd1;
                end
              end
            end
          end
          StSrOut: begin
            // Each byte boundary re-samples the live register so BUSY polling sees it drop.
            if (sclk_fall) begin
              oe_q <= 4'b0010;
              if (bit_cnt_q == '0) begin
                out_q     <= {2'b00, sr_live[7], 1'b0};
                shift_q   <= {sr_live[6:0], 1'b0};
                bit_cnt_q <= 5'd7;
              end else begin
                out_q     <= {2'b00, shift_q[7], 1'b0};
                shift_q   <= {shift_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q - 5'd1;
              end
            end
          end
          StSrIn: begin
            if (sclk_rise && sr_in_cnt_q != 5'd16) begin
              sr_in_q     <= {sr_in_q[14:0], io_s[0]};
              sr_in_cnt_q <= sr_in_cnt_q + 5'd1;
            end
          end
          StIgnore: begin
            oe_q <= '0;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign IO0 = oe_q[0] ? out_q[0] : 1'bz;
  assign IO1 = oe_q[1] ? out_q[1] : 1'bz;
  assign IO2 = oe_q[2] ? out_q[2] : 1'bz;
  assign IO3 = oe_q[3] ? out_q[3] : 1'bz;

  assign bus.sr1 = sr1_q;
  assign bus.sr2 = sr2_q;

endmodule

// File: tb/tb_spi_flash_model.sv
// Directed and randomised bench for spi_flash_model with a behavioural flash model.
module tb_spi_flash_model;
  import spi_flash_pkg::*;

  localparam int unsigned MEM_DEPTH   = 256;
  localparam int unsigned BUSY_CYCLES = 300;
  localparam logic [7:0]  SR2_RESET   = 8'h00;

  logic ACLK;
  logic ARESET;
  wire  IO0, IO1, IO2, IO3;
  logic m_oe, m_d;

  // Pull-ups make a released line read as 1, so a line stuck driving 0 is visible.
  pullup (IO0);
  pullup (IO1);
  pullup (IO2);
  pullup (IO3);
  assign IO0 = m_oe ? m_d : 1'bz;

  spi_flash_model_if #(.MEM_DEPTH(MEM_DEPTH)) bus ();

  spi_flash_model #(
    .MEM_DEPTH   (MEM_DEPTH),
    .BUSY_CYCLES (BUSY_CYCLES),
    .SR2_RESET   (SR2_RESET)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .IO0    (IO0),
    .IO1    (IO1),
    .IO2    (IO2),
    .IO3    (IO3),
    .bus    (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks;
  int errors;

  logic [7:0] mdl_mem [MEM_DEPTH];
  logic [7:0] mdl_sr1w;
  logic [7:0] mdl_sr2;
  logic       mdl_wel;

  function automatic logic [7:0] exp_sr1();
    return {mdl_sr1w[7:2], mdl_wel, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic cs_low();
    bus.CS_N = 1'b0;
    wait_clks(5);
  endtask

  task automatic cs_high();
    wait_clks(5);
    bus.CS_N = 1'b1;
    wait_clks(10);
  endtask

  task automatic send_bit(input logic b);
    m_d = b;
    wait_clks(5);
    bus.SCLK = 1'b1;
    wait_clks(5);
    bus.SCLK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wait_clks(5);
      b[i] = IO1;
      bus.SCLK = 1'b1;
      wait_clks(5);
      bus.SCLK = 1'b0;
    end
  endtask

  task automatic recv_quad(output logic [7:0] b);
    for (int i = 1; i >= 0; i--) begin
      wait_clks(5);
      b[i*4 +: 4] = {IO3, IO2, IO1, IO0};
      bus.SCLK = 1'b1;
      wait_clks(5);
      bus.SCLK = 1'b0;
    end
  endtask

  task automatic simple_cmd(input logic [7:0] op);
    cs_low();
    send_byte(op);
    cs_high();
    if (op == OP_WREN) mdl_wel = 1'b1;
    if (op == OP_WRDI) mdl_wel = 1'b0;
  endtask

  task automatic rdsr_check(input string tag, input logic [7:0] op, input int n);
    logic [7:0] b;
    cs_low();
    send_byte(op);
    for (int k = 0; k < n; k++) begin
      recv_byte(b);
      check(tag, 32'(b), 32'(op == OP_RDSR2 ? mdl_sr2 : exp_sr1()));
    end
    cs_high();
  endtask

  task automatic wait_not_busy(input string tag);
    int c;
    c = 0;
    while (bus.sr1[SR_BUSY] && c < BUSY_CYCLES + 100) begin
      wait_clks(1);
      c++;
    end
    if (bus.sr1[SR_BUSY]) check(tag, 32'(bus.sr1[SR_BUSY]), 32'(0));
  endtask

  // Full 16-bit WRSR; model applies it only when WEL was set.
  task automatic wrsr(input logic [7:0] a, input logic [7:0] b);
    cs_low();
    send_byte(OP_WRSR);
    send_byte(a);
    send_byte(b);
    cs_high();
    if (mdl_wel) begin
      wait_not_busy("wrsr_busy_timeout");
      mdl_sr1w = {a[7:2], 2'b00};
      mdl_sr2  = b;
      mdl_wel  = 1'b0;
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    bus.pre_addr  = a;
    bus.pre_wdata = d;
    bus.pre_we    = 1'b1;
    wait_clks(1);
    bus.pre_we    = 1'b0;
    mdl_mem[a]    = d;
  endtask

  task automatic read_check(input string tag, input logic quad, input logic [7:0] a,
                            input int n);
    logic [7:0] b;
    cs_low();
    send_byte(quad ? OP_QREAD : OP_READ);
    send_addr({16'h0000, a});
    if (quad) begin
      m_oe = 1'b0;
      send_byte(8'h00);
    end
    for (int k = 0; k < n; k++) begin
      if (quad) recv_quad(b);
      else      recv_byte(b);
      // A quad read with QE clear leaves every line released.
      if (quad && !mdl_sr2[SR_QE]) check(tag, 32'(b), 32'hFF);
      else check(tag, 32'(b), 32'(mdl_mem[8'(a + 8'(k))]));
    end
    cs_high();
    m_oe = 1'b1;
  endtask

  initial begin
    logic [7:0] b, r1, r2, base;
    int n, c;
    checks        = 0;
    errors        = 0;
    ARESET        = 1'b1;
    bus.SCLK      = 1'b0;
    bus.CS_N      = 1'b1;
    bus.pre_we    = 1'b0;
    bus.pre_addr  = '0;
    bus.pre_wdata = '0;
    m_oe          = 1'b1;
    m_d           = 1'b0;
    mdl_sr1w      = 8'h00;
    mdl_sr2       = SR2_RESET;
    mdl_wel       = 1'b0;
    wait_clks(5);
    ARESET = 1'b0;
    wait_clks(2);

    check("rst_sr1", 32'(bus.sr1), 32'h00);
    check("rst_sr2", 32'(bus.sr2), 32'(SR2_RESET));
    check("rst_io1_released", 32'(IO1), 32'h1);

    rdsr_check("rdsr1_1byte", OP_RDSR1, 1);
    rdsr_check("rdsr1_2byte", OP_RDSR1, 2);

    simple_cmd(OP_WREN);
    rdsr_check("wren_rdsr1", OP_RDSR1, 1);
    check("wren_sr1_port", 32'(bus.sr1), 32'h02);
    simple_cmd(OP_WRDI);
    rdsr_check("wrdi_rdsr1", OP_RDSR1, 1);

    // WRSR FC/02 then poll SR1 in one continuous command.
    simple_cmd(OP_WREN);
    cs_low();
    send_byte(OP_WRSR);
    send_byte(8'hFC);
    send_byte(8'h02);
    cs_high();
    cs_low();
    send_byte(OP_RDSR1);
    b = 8'h00;
    for (int k = 0; k < 12; k++) begin
      recv_byte(b);
      if (b == 8'hFC) break;
      check("busy_poll_ff", 32'(b), 32'hFF);
    end
    check("busy_poll_end", 32'(b), 32'hFC);
    cs_high();
    mdl_sr1w = 8'hFC;
    mdl_sr2  = 8'h02;
    mdl_wel  = 1'b0;
    rdsr_check("rdsr2_after_wrsr", OP_RDSR2, 1);

    // Random WRSR with exact BUSY length measured on the port.
    r1 = 8'($urandom);
    r2 = 8'($urandom) | 8'h02;
    simple_cmd(OP_WREN);
    cs_low();
    send_byte(OP_WRSR);
    send_byte(r1);
    send_byte(r2);
    wait_clks(5);
    bus.CS_N = 1'b1;
    c = 0;
    while (!bus.sr1[SR_BUSY] && c < 10) begin
      wait_clks(1);
      c++;
    end
    n = 0;
    while (bus.sr1[SR_BUSY] && n < BUSY_CYCLES + 50) begin
      n++;
      wait_clks(1);
    end
    check("busy_length", 32'(n), 32'(BUSY_CYCLES));
    mdl_sr1w = {r1[7:2], 2'b00};
    mdl_sr2  = r2;
    mdl_wel  = 1'b0;
    check("rand_wrsr_sr1", 32'(bus.sr1), 32'(exp_sr1()));
    check("rand_wrsr_sr2", 32'(bus.sr2), 32'(mdl_sr2));

    // WRSR without WREN has no effect.
    wrsr(8'($urandom), 8'($urandom));
    check("wrsr_nowel_sr1", 32'(bus.sr1), 32'(exp_sr1()));
    check("wrsr_nowel_sr2", 32'(bus.sr2), 32'(mdl_sr2));

    // WRSR cut short after 8 bits: registers untouched, WEL still set.
    simple_cmd(OP_WREN);
    cs_low();
    send_byte(OP_WRSR);
    send_byte(8'($urandom));
    cs_high();
    check("wrsr_short_sr1", 32'(bus.sr1), 32'(exp_sr1()));
    check("wrsr_short_sr2", 32'(bus.sr2), 32'(mdl_sr2));
    simple_cmd(OP_WRDI);

    // Single read across the top of the array.
    preload(8'hFE, 8'hA5);
    preload(8'hFF, 8'h3C);
    preload(8'h00, 8'h11);
    read_check("read_wrap", 1'b0, 8'hFE, 3);

    for (int t = 0; t < 2; t++) begin
      base = 8'($urandom);
      for (int k = 0; k < 3; k++) preload(8'(base + 8'(k)), 8'($urandom));
      read_check("read_rand", 1'b0, base, 3);
    end

    // Quad read with QE set.
    simple_cmd(OP_WREN);
    wrsr(8'h00, 8'h02);
    preload(8'h10, 8'hDE);
    read_check("qread_de", 1'b1, 8'h10, 1);
    base = 8'($urandom);
    for (int k = 0; k < 2; k++) preload(8'(base + 8'(k)), 8'($urandom));
    read_check("qread_rand", 1'b1, base, 2);

    // Quad read with QE clear: ignored.
    simple_cmd(OP_WREN);
    wrsr(8'h00, 8'h00);
    check("qe_clear_sr2", 32'(bus.sr2), 32'h00);
    read_check("qread_qe0", 1'b1, 8'h10, 1);

    // Abort after 10 address bits.
    cs_low();
    send_byte(OP_READ);
    for (int k = 0; k < 10; k++) send_bit(1'b0);
    bus.CS_N = 1'b1;
    wait_clks(3);
    check("abort_addr_io1", 32'(IO1), 32'h1);
    wait_clks(10);
    rdsr_check("abort_then_rdsr1", OP_RDSR1, 1);

    // Abort while driving data: line released within 3 clocks.
    preload(8'h40, 8'h00);
    cs_low();
    send_byte(OP_READ);
    send_addr(24'h000040);
    wait_clks(5);
    check("abort_data_driving", 32'(IO1), 32'h0);
    bus.CS_N = 1'b1;
    wait_clks(3);
    check("abort_data_released", 32'(IO1), 32'h1);
    wait_clks(10);

    // Reset in the middle of BUSY.
    simple_cmd(OP_WREN);
    cs_low();
    send_byte(OP_WRSR);
    send_byte(8'hA8);
    send_byte(8'h55);
    cs_high();
    check("midbusy_busy_set", 32'(bus.sr1[SR_BUSY]), 32'h1);
    ARESET = 1'b1;
    wait_clks(1);
    check("reset_midbusy_sr1", 32'(bus.sr1), 32'h00);
    check("reset_midbusy_sr2", 32'(bus.sr2), 32'(SR2_RESET));
    ARESET = 1'b0;
    mdl_sr1w = 8'h00;
    mdl_sr2  = SR2_RESET;
    mdl_wel  = 1'b0;
    wait_clks(BUSY_CYCLES + 5);
    check("reset_busy_stays_clear", 32'(bus.sr1), 32'h00);

    // Array contents survive reset.
    read_check("read_after_reset", 1'b0, 8'hFE, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
